// File: rtl/match_req_initiator_pkg.sv
// Shared definitions for the match request initiator: address/length widths,
// FSM state encoding and the best-match comparison.
package match_req_initiator_pkg;

  localparam int ADDR_WIDTH         = 16;
  localparam int MAX_MATCH_LEN_LOG2 = 8;
  localparam int LEN_W              = MAX_MATCH_LEN_LOG2 + 1;
  localparam int MAX_MATCH_LEN      = 258;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } state_t;

  // Longer match wins; on a tie the larger history address (nearer) wins.
  function automatic logic is_better(input logic [LEN_W-1:0]      len,
                                     input logic [ADDR_WIDTH-1:0] hist,
                                     input logic [LEN_W-1:0]      best_len,
                                     input logic [ADDR_WIDTH-1:0] best_hist);
    return (len > best_len) || ((len == best_len) && (hist > best_hist));
  endfunction

endpackage

// File: rtl/match_tag_allocator.sv
// Outstanding-slot allocator: busy bitmap, lowest-free priority encode and an
// in-flight count. Frees take effect on the next clock, so a slot released in
// one cycle is visible as free (and allocatable) only from the following cycle.
module match_tag_allocator
  import match_req_initiator_pkg::*;
#(
  parameter  int OUTSTANDING = 4,
  localparam int SLOT_W      = $clog2(OUTSTANDING),
  localparam int CNT_W       = $clog2(OUTSTANDING + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_alloc,
  input  logic                   i_free,
  input  logic [SLOT_W-1:0]      i_free_idx,
  output logic                   o_any_free,
  output logic [SLOT_W-1:0]      o_alloc_idx,
  output logic [OUTSTANDING-1:0] o_busy,
  output logic [CNT_W-1:0]       o_count
);

  logic [OUTSTANDING-1:0] r_busy;
  logic [CNT_W-1:0]       r_count;
  logic [SLOT_W-1:0]      w_low_idx;
  logic [OUTSTANDING-1:0] w_alloc_mask;
  logic [OUTSTANDING-1:0] w_free_mask;

  // Priority encode: lowest-index slot that is not busy
  always_comb begin
    w_low_idx = '0;
    for (int i = OUTSTANDING - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_low_idx = SLOT_W'(i);
    end
  end

  // One-hot set/clear masks for this cycle's allocate and free
  always_comb begin
    w_alloc_mask = '0;
    w_free_mask  = '0;
    if (i_alloc) w_alloc_mask[w_low_idx]  = 1'b1;
    if (i_free)  w_free_mask[i_free_idx]  = 1'b1;
  end

  // Busy bitmap and count; alloc and free in the same cycle net to no change
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy <= (r_busy | w_alloc_mask) & ~w_free_mask;
      case ({i_alloc, i_free})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_any_free  = ~&r_busy;
  assign o_alloc_idx = w_low_idx;
  assign o_busy      = r_busy;
  assign o_count     = r_count;

endmodule

// File: rtl/match_req_initiator.sv
// Job-side initiator of the match request/response protocol. Tags each
// candidate with a free slot, issues it to the match PE, collects out-of-order
// responses and reports the best match of the job.
// Optional feature macro: MATCH_INIT_EARLY_TERM_EN -- once the best length of
// the job reaches MAX_MATCH_LEN, remaining candidates are consumed unissued.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no job open; first candidate latches head and clears best
// ST_ISSUE  | job open, issuing candidates until the last one
// ST_DRAIN  | all candidates taken, waiting for outstanding responses
// ST_RESULT | job result presented and held until i_job_ready
module match_req_initiator
  import match_req_initiator_pkg::*;
#(
  parameter int TAG_BITS      = 8,
  parameter int OUTSTANDING   = 4,
  parameter int MIN_MATCH_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_cand_valid,
  output logic                  o_cand_ready,
  input  logic [ADDR_WIDTH-1:0] i_cand_head_addr,
  input  logic [ADDR_WIDTH-1:0] i_cand_history_addr,
  input  logic                  i_cand_last,
  output logic                  o_match_req_valid,
  input  logic                  i_match_req_ready,
  output logic [TAG_BITS-1:0]   o_match_req_tag,
  output logic [ADDR_WIDTH-1:0] o_match_req_head_addr,
  output logic [ADDR_WIDTH-1:0] o_match_req_history_addr,
  input  logic                  i_match_resp_valid,
  output logic                  o_match_resp_ready,
  input  logic [TAG_BITS-1:0]   i_match_resp_tag,
  input  logic [LEN_W-1:0]      i_match_resp_match_len,
  output logic                  o_job_valid,
  input  logic                  i_job_ready,
  output logic [ADDR_WIDTH-1:0] o_job_head_addr,
  output logic [LEN_W-1:0]      o_job_match_len,
  output logic [ADDR_WIDTH-1:0] o_job_history_addr
);

  localparam int SLOT_W = $clog2(OUTSTANDING);
  localparam int CNT_W  = $clog2(OUTSTANDING + 1);

  state_t                 r_state;
  state_t                 w_next_state;
  logic [ADDR_WIDTH-1:0]  r_head;
  logic [LEN_W-1:0]       r_best_len;
  logic [ADDR_WIDTH-1:0]  r_best_hist;
  logic [ADDR_WIDTH-1:0]  r_slot_hist [OUTSTANDING];

  logic                   w_any_free;
  logic [SLOT_W-1:0]      w_alloc_idx;
  logic [OUTSTANDING-1:0] w_busy;
  logic [CNT_W-1:0]       w_count;

  logic                   w_accept_state;
  logic                   w_skip;
  logic                   w_cand_ready;
  logic                   w_req_valid;
  logic                   w_job_valid;
  logic                   w_cand_fire;
  logic                   w_alloc;

  logic                   w_resp_in_range;
  logic [SLOT_W-1:0]      w_resp_idx;
  logic                   w_resp_ok;
  logic [ADDR_WIDTH-1:0]  w_resp_hist;

  assign w_cand_fire     = i_cand_valid & w_cand_ready;
  assign w_alloc         = w_cand_fire & ~w_skip;

  // Responses for tags outside the slot range or for idle slots are dropped
  assign w_resp_in_range = ({1'b0, i_match_resp_tag} < (TAG_BITS + 1)'(OUTSTANDING));
  assign w_resp_idx      = i_match_resp_tag[SLOT_W-1:0];
  assign w_resp_ok       = i_match_resp_valid & w_resp_in_range & w_busy[w_resp_idx];
  assign w_resp_hist     = r_slot_hist[w_resp_idx];

  match_tag_allocator #(
    .OUTSTANDING (OUTSTANDING)
  ) u_tag_alloc (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_alloc     (w_alloc),
    .i_free      (w_resp_ok),
    .i_free_idx  (w_resp_idx),
    .o_any_free  (w_any_free),
    .o_alloc_idx (w_alloc_idx),
    .o_busy      (w_busy),
    .o_count     (w_count)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next-state; DRAIN exits on the registered count, so the result
  // appears one clock after the edge that accepted the final response
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_cand_fire) w_next_state = i_cand_last ? ST_DRAIN : ST_ISSUE;
      ST_ISSUE:  if (w_cand_fire && i_cand_last) w_next_state = ST_DRAIN;
      ST_DRAIN:  if (w_count == '0) w_next_state = ST_RESULT;
      ST_RESULT: if (i_job_ready) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: zero-latency issue path gated by state and slot availability
  always_comb begin
    w_accept_state = (r_state == ST_IDLE) || (r_state == ST_ISSUE);
`ifdef MATCH_INIT_EARLY_TERM_EN
    w_skip = (r_state == ST_ISSUE) && (r_best_len == LEN_W'(MAX_MATCH_LEN));
`else
    w_skip = 1'b0;
`endif
    w_cand_ready = w_skip | (w_accept_state & w_any_free & i_match_req_ready);
    w_req_valid  = ~w_skip & w_accept_state & w_any_free & i_cand_valid;
    w_job_valid  = (r_state == ST_RESULT);
  end

  // Per-slot history address, captured when the slot is handed out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < OUTSTANDING; i++) r_slot_hist[i] <= '0;
    end else if (w_alloc) begin
      r_slot_hist[w_alloc_idx] <= i_cand_history_addr;
    end
  end

  // Job head and running best; a new job clears the best before any response
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head      <= '0;
      r_best_len  <= '0;
      r_best_hist <= '0;
    end else if ((r_state == ST_IDLE) && w_cand_fire) begin
      r_head      <= i_cand_head_addr;
      r_best_len  <= '0;
      r_best_hist <= '0;
    end else if (w_resp_ok &&
                 is_better(i_match_resp_match_len, w_resp_hist, r_best_len, r_best_hist)) begin
      r_best_len  <= i_match_resp_match_len;
      r_best_hist <= w_resp_hist;
    end
  end

`ifndef SYNTHESIS
  // Flag responses that do not correspond to any in-flight request
  always_ff @(posedge clk) begin
    if (rst_n && i_match_resp_valid && !w_resp_ok)
      $error("match_req_initiator: response to unallocated tag %0d", i_match_resp_tag);
  end
`endif

  assign o_cand_ready             = w_cand_ready;
  assign o_match_req_valid        = w_req_valid;
  assign o_match_req_tag          = TAG_BITS'(w_alloc_idx);
  assign o_match_req_head_addr    = i_cand_head_addr;
  assign o_match_req_history_addr = i_cand_history_addr;
  assign o_match_resp_ready       = 1'b1;
  assign o_job_valid              = w_job_valid;
  assign o_job_head_addr          = r_head;
  assign o_job_match_len          = (r_best_len < LEN_W'(MIN_MATCH_LEN)) ? '0 : r_best_len;
  assign o_job_history_addr       = r_best_hist;

endmodule
